clint_bridge: RTL and testbench
===============================

// Module: clint_bridge
// PURPOSE
//  Bus-side front end of the CLINT: accepts one core data request at a time and rebases the address to a CLINT offset.
//  Issues a one-cycle clint_valid access and returns a single response with ready/error.
//  Also provides a coherent 64-bit mtime read: a low-word read snapshots the high word, so the following high-word read cannot tear.
//  Sits between the data-side peripheral decoder and clint.
// PARAMETERS
//  CLINT_BASE  32'h0200_0000  byte base of the 64 KiB CLINT window
//  TIMEOUT     15             WAIT cycles without clint_ready before an error response (1..255)
// PORTS
//  rst          in   1   synchronous reset, active low
//  clk          in   1   clock, all state on rising edge
//  mem_valid    in   1   request strobe, sampled only in IDLE
//  mem_instr    in   1   1 = instruction fetch
//  mem_addr     in   32  byte address
//  mem_wdata    in   32  write data
//  mem_wstrb    in   4   byte strobes; 0 = read
//  mem_rdata    out  32  response data, valid with mem_ready
//  mem_ready    out  1   one-cycle response pulse
//  mem_error    out  1   qualifies mem_ready; access faulted
//  clint_valid  out  1   one-cycle access strobe to clint
//  clint_instr  out  1   always 0
//  clint_addr   out  32  mem_addr - CLINT_BASE
//  clint_wdata  out  32  registered mem_wdata
//  clint_wstrb  out  4   registered mem_wstrb
//  clint_rdata  in   32  clint read data
//  clint_ready  in   1   clint completion pulse
//  clint_mtime  in   64  live mtime from clint
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=IDLE, all outputs 0, shadow_hi=0, shadow_vld=0, counter=0.
//  Reset mid-transaction aborts it; no response is produced.
//  FSM states: IDLE, REQ, WAIT, RESP. Registered outputs.
//  IDLE, mem_valid=1: latch instr, addr, wdata, wstrb, then select exactly one branch:
//   - fault (mem_instr=1, addr outside [BASE, BASE+0x10000), or addr[1:0]!=0) -> RESP, error=1, rdata=0
//   - shadowed high read (offset 0xBFFC, wstrb=0, shadow_vld=1) -> RESP, rdata=shadow_hi, shadow_vld<=0; no clint access
//   - otherwise -> REQ
//  REQ: clint_valid=1 for exactly one cycle, counter<=0, go WAIT.
//   If offset==0xBFF8 and wstrb==0: shadow_hi<=clint_mtime[63:32] this cycle, shadow_vld<=1.
//  WAIT, clint_ready=1: RESP with rdata=clint_rdata, error=0.
//  WAIT, no ready, counter==TIMEOUT: RESP with error=1, rdata=0.
//  WAIT, otherwise: counter+1 (8-bit, never wraps since TIMEOUT<=255).
//  RESP: mem_ready=1 (plus mem_error, mem_rdata) for one cycle, then IDLE. Data/error outputs return to 0 outside RESP.
//  Latency: normal access mem_ready 3 cycles after mem_valid; fault or shadow hit 1 cycle.
//  mem_valid outside IDLE is ignored; requester holds off until mem_ready.
//  Any write to offset 0xBFF8 or 0xBFFC clears shadow_vld when issued.
//  Unshadowed high read goes to clint normally.
//  clint_ready in IDLE, REQ or RESP is ignored.
// TESTING
//  1. Read 0x0200_BFF8 while mtime=0x1_FFFF_FFFF (increment in flight) -> low word, then read 0x0200_BFFC in 1 cycle -> 0x1 (shadow), no clint_valid.
//  2. Write 0x0200_4000 data 0x100, wstrb=F -> clint_valid one cycle with clint_addr=0x4000; mem_ready at cycle 3, mem_error=0.
//  3. Read 0x0200_0100 (unmapped in clint, no ready) -> mem_ready+mem_error exactly TIMEOUT+3 cycles after mem_valid (18 at default).
//  4. mem_instr=1 to 0x0200_0000, or addr 0x0201_0000, or 0x0200_0002 -> error response at cycle 1, clint_valid never asserted.
//  5. Read 0xBFF8, write 0xBFFC=0, read 0xBFFC -> third access goes to clint (shadow cleared), returns 0.
//  6. rst=0 during WAIT -> next cycle all outputs 0, state IDLE; a new request completes normally.

Source files
------------

// File: rtl/clint_bridge_if.sv
// Bus bundle between the data-side requester, the bridge and the CLINT core.
// The bridge takes the slave view; the requester/CLINT side takes the master view.
interface clint_bridge_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;

    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic [63:0] clint_mtime;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready, mem_error,
        input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready, clint_mtime
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready, mem_error,
        output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready, clint_mtime
    );
endinterface

// File: rtl/clint_bridge.sv
// CLINT bus front end: one request at a time, address rebasing, timeout errors
// and a snapshot of mtime[63:32] so a low-then-high mtime read cannot tear.
//
// state | meaning
// IDLE  | waiting for mem_valid; faults and shadow hits answered directly
// REQ   | clint_valid high for this one cycle
// WAIT  | waiting for clint_ready or timeout
// RESP  | mem_ready pulse with mem_rdata / mem_error
module clint_bridge #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst,
    clint_bridge_if.slave bus
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_REQ  = 2'd1;
    localparam logic [1:0]  S_WAIT = 2'd2;
    localparam logic [1:0]  S_RESP = 2'd3;

    localparam logic [7:0]  TIMEOUT_CNT  = 8'(TIMEOUT);
    localparam logic [31:0] WINDOW       = 32'h0001_0000;
    localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
    localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shadow_hi_q, shadow_hi_d;
    logic        shadow_vld_q, shadow_vld_d;

    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic        mem_error_q, mem_error_d;
    logic        clint_valid_q, clint_valid_d;
    logic [31:0] clint_addr_q, clint_addr_d;
    logic [31:0] clint_wdata_q, clint_wdata_d;
    logic [3:0]  clint_wstrb_q, clint_wstrb_d;

    logic [31:0] req_off;
    logic        req_fault;
    logic        req_shadow_hit;
    logic        unused_mtime_lo;

    // Unsigned wrap of the subtraction makes addresses below the base land outside the window too.
    assign req_off        = bus.mem_addr - CLINT_BASE;
    assign req_fault      = bus.mem_instr || (req_off >= WINDOW) || (bus.mem_addr[1:0] != 2'b00);
    assign req_shadow_hit = (req_off == OFF_MTIME_HI) && (bus.mem_wstrb == 4'h0) && shadow_vld_q;

    assign unused_mtime_lo = ^bus.clint_mtime[31:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_hi_d   = shadow_hi_q;
        shadow_vld_d  = shadow_vld_q;
        mem_rdata_d   = 32'h0;
        mem_ready_d   = 1'b0;
        mem_error_d   = 1'b0;
        clint_valid_d = 1'b0;
        clint_addr_d  = clint_addr_q;
        clint_wdata_d = clint_wdata_q;
        clint_wstrb_d = clint_wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    clint_addr_d  = req_off;
                    clint_wdata_d = bus.mem_wdata;
                    clint_wstrb_d = bus.mem_wstrb;
                    if (req_fault) begin
                        state_d     = S_RESP;
                        mem_ready_d = 1'b1;
                        mem_error_d = 1'b1;
                    end else if (req_shadow_hit) begin
                        state_d      = S_RESP;
                        mem_ready_d  = 1'b1;
                        mem_rdata_d  = shadow_hi_q;
                        shadow_vld_d = 1'b0;
                    end else begin
                        state_d       = S_REQ;
                        clint_valid_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = 8'd0;
                if (clint_addr_q == OFF_MTIME_LO && clint_wstrb_q == 4'h0) begin
                    shadow_hi_d  = bus.clint_mtime[63:32];
                    shadow_vld_d = 1'b1;
                end else if (clint_wstrb_q != 4'h0 &&
                             (clint_addr_q == OFF_MTIME_LO || clint_addr_q == OFF_MTIME_HI)) begin
                    shadow_vld_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.clint_ready) begin
                    state_d     = S_RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = bus.clint_rdata;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d     = S_RESP;
                    mem_ready_d = 1'b1;
                    mem_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            shadow_hi_q   <= 32'h0;
            shadow_vld_q  <= 1'b0;
            mem_rdata_q   <= 32'h0;
            mem_ready_q   <= 1'b0;
            mem_error_q   <= 1'b0;
            clint_valid_q <= 1'b0;
            clint_addr_q  <= 32'h0;
            clint_wdata_q <= 32'h0;
            clint_wstrb_q <= 4'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_hi_q   <= shadow_hi_d;
            shadow_vld_q  <= shadow_vld_d;
            mem_rdata_q   <= mem_rdata_d;
            mem_ready_q   <= mem_ready_d;
            mem_error_q   <= mem_error_d;
            clint_valid_q <= clint_valid_d;
            clint_addr_q  <= clint_addr_d;
            clint_wdata_q <= clint_wdata_d;
            clint_wstrb_q <= clint_wstrb_d;
        end
    end

    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.mem_ready   = mem_ready_q;
    assign bus.mem_error   = mem_error_q;
    assign bus.clint_valid = clint_valid_q;
    assign bus.clint_instr = 1'b0;
    assign bus.clint_addr  = clint_addr_q;
    assign bus.clint_wdata = clint_wdata_q;
    assign bus.clint_wstrb = clint_wstrb_q;
endmodule

// File: tb/tb_clint_bridge.sv
// Directed bench for clint_bridge with a small CLINT responder model.
// Inputs change and outputs are sampled on the falling edge.
module tb_clint_bridge;
    logic clk = 1'b0;
    logic rst;

    clint_bridge_if bus_if ();

    clint_bridge #(
        .CLINT_BASE (32'h0200_0000),
        .TIMEOUT    (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // CLINT responder: answers one cycle after seeing clint_valid, except offset 0x100.
    logic [31:0] regs [logic [31:0]];
    int          valid_cnt = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        pend;
    logic [31:0] pend_data;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (regs.exists(a))          return regs[a];
        else if (a == 32'h0000_BFF8) return bus_if.clint_mtime[31:0];
        else if (a == 32'h0000_BFFC) return bus_if.clint_mtime[63:32];
        else                         return 32'h0;
    endfunction

    initial begin
        bus_if.clint_ready = 1'b0;
        bus_if.clint_rdata = 32'h0;
        pend       = 1'b0;
        pend_data  = 32'h0;
        last_addr  = 32'h0;
        last_wdata = 32'h0;
        last_wstrb = 4'h0;
        forever begin
            @(negedge clk);
            bus_if.clint_ready = 1'b0;
            bus_if.clint_rdata = 32'h0;
            if (pend) begin
                bus_if.clint_ready = 1'b1;
                bus_if.clint_rdata = pend_data;
                pend = 1'b0;
            end
            if (bus_if.clint_valid) begin
                valid_cnt++;
                last_addr  = bus_if.clint_addr;
                last_wdata = bus_if.clint_wdata;
                last_wstrb = bus_if.clint_wstrb;
                if (bus_if.clint_addr != 32'h0000_0100) begin
                    pend = 1'b1;
                    if (bus_if.clint_wstrb != 4'h0) begin
                        regs[bus_if.clint_addr] = bus_if.clint_wdata;
                        pend_data = 32'h0;
                    end else begin
                        pend_data = model_read(bus_if.clint_addr);
                    end
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the response.
    task automatic access(input string tag, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic err, output int lat);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_instr = instr;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        bus_if.mem_wstrb = wstrb;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus_if.mem_valid = 1'b0;
                bus_if.mem_instr = 1'b0;
                bus_if.mem_wstrb = 4'h0;
            end
            if (bus_if.mem_ready) begin
                lat   = i;
                rdata = bus_if.mem_rdata;
                err   = bus_if.mem_error;
                break;
            end
        end
        if (lat == 0) chk({tag, "_no_response"}, 64'(lat), 64'd1);
        @(negedge clk);
        chk({tag, "_ready_one_cycle"}, 64'(bus_if.mem_ready), 64'd0);
        chk({tag, "_outputs_clear"}, {31'h0, bus_if.mem_error, bus_if.mem_rdata}, 64'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          v0;
    int          seen;

    initial begin
        rst = 1'b0;
        bus_if.mem_valid   = 1'b0;
        bus_if.mem_instr   = 1'b0;
        bus_if.mem_addr    = 32'h0;
        bus_if.mem_wdata   = 32'h0;
        bus_if.mem_wstrb   = 4'h0;
        bus_if.clint_mtime = 64'h0000_0001_FFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_mem_ready", 64'(bus_if.mem_ready), 64'd0);
        chk("rst_mem_error", 64'(bus_if.mem_error), 64'd0);
        chk("rst_mem_rdata", 64'(bus_if.mem_rdata), 64'd0);
        chk("rst_clint_valid", 64'(bus_if.clint_valid), 64'd0);
        chk("rst_clint_addr", 64'(bus_if.clint_addr), 64'd0);
        chk("rst_clint_wdata_wstrb", {28'h0, bus_if.clint_wstrb, bus_if.clint_wdata}, 64'd0);
        chk("rst_clint_instr", 64'(bus_if.clint_instr), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: low read snapshots high word; high read served from shadow
        v0 = valid_cnt;
        access("mt_lo", 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, rd, er, lat);
        chk("mt_lo_data", 64'(rd), 64'hFFFF_FFFF);
        chk("mt_lo_lat", 64'(lat), 64'd3);
        chk("mt_lo_err", 64'(er), 64'd0);
        chk("mt_lo_addr", 64'(last_addr), 64'h0000_BFF8);
        bus_if.clint_mtime = 64'h0000_0002_0000_0000;
        v0 = valid_cnt;
        access("mt_hi", 1'b0, 32'h0200_BFFC, 32'h0, 4'h0, rd, er, lat);
        chk("mt_hi_shadow_data", 64'(rd), 64'h1);
        chk("mt_hi_shadow_lat", 64'(lat), 64'd1);
        chk("mt_hi_no_clint", 64'(valid_cnt - v0), 64'd0);

        // 2: normal write
        v0 = valid_cnt;
        access("wr", 1'b0, 32'h0200_4000, 32'h0000_0100, 4'hF, rd, er, lat);
        chk("wr_lat", 64'(lat), 64'd3);
        chk("wr_err", 64'(er), 64'd0);
        chk("wr_valid_cycles", 64'(valid_cnt - v0), 64'd1);
        chk("wr_addr", 64'(last_addr), 64'h0000_4000);
        chk("wr_wdata", 64'(last_wdata), 64'h100);
        chk("wr_wstrb", 64'(last_wstrb), 64'hF);
        access("rdback", 1'b0, 32'h0200_4000, 32'h0, 4'h0, rd, er, lat);
        chk("rdback_data", 64'(rd), 64'h100);

        // 3: timeout
        access("tmo", 1'b0, 32'h0200_0100, 32'h0, 4'h0, rd, er, lat);
        chk("tmo_lat", 64'(lat), 64'd18);
        chk("tmo_err", 64'(er), 64'd1);
        chk("tmo_data", 64'(rd), 64'd0);

        // 4: faults
        v0 = valid_cnt;
        access("f_instr", 1'b1, 32'h0200_0000, 32'h0, 4'h0, rd, er, lat);
        chk("f_instr_lat", 64'(lat), 64'd1);
        chk("f_instr_err", 64'(er), 64'd1);
        access("f_range", 1'b0, 32'h0201_0000, 32'h0, 4'h0, rd, er, lat);
        chk("f_range_lat", 64'(lat), 64'd1);
        chk("f_range_err", 64'(er), 64'd1);
        access("f_below", 1'b0, 32'h01FF_FFFC, 32'h0, 4'h0, rd, er, lat);
        chk("f_below_err", 64'(er), 64'd1);
        access("f_align", 1'b0, 32'h0200_0002, 32'h0, 4'hF, rd, er, lat);
        chk("f_align_lat", 64'(lat), 64'd1);
        chk("f_align_err_data", {31'h0, er, rd}, 64'h1_0000_0000);
        chk("f_no_clint", 64'(valid_cnt - v0), 64'd0);

        // 5: write to mtime high clears the shadow
        access("s5_lo", 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, rd, er, lat);
        chk("s5_lo_data", 64'(rd), 64'h0);
        access("s5_wr", 1'b0, 32'h0200_BFFC, 32'h0, 4'hF, rd, er, lat);
        chk("s5_wr_lat", 64'(lat), 64'd3);
        v0 = valid_cnt;
        access("s5_hi", 1'b0, 32'h0200_BFFC, 32'h0, 4'h0, rd, er, lat);
        chk("s5_hi_data", 64'(rd), 64'h0);
        chk("s5_hi_lat", 64'(lat), 64'd3);
        chk("s5_hi_to_clint", 64'(valid_cnt - v0), 64'd1);

        // 6: reset during WAIT aborts without a response
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = 32'h0200_0100;
        bus_if.mem_wstrb = 4'h0;
        @(negedge clk);
        bus_if.mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {29'h0, bus_if.mem_ready, bus_if.mem_error, bus_if.clint_valid,
                              bus_if.mem_rdata}, 64'd0);
        chk("abort_clint_addr", 64'(bus_if.clint_addr), 64'd0);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.mem_ready) seen++;
        end
        chk("abort_no_resp", 64'(seen), 64'd0);
        access("post_rst", 1'b0, 32'h0200_4000, 32'h0, 4'h0, rd, er, lat);
        chk("post_rst_data", 64'(rd), 64'h100);
        chk("post_rst_lat", 64'(lat), 64'd3);
        chk("post_rst_err", 64'(er), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
